// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port message memory.
// Bounded bursts per requester; read data returns one cycle later with a per-requester valid strobe.
module mem_arbiter #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 5,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              rw0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic              mem_o_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic {
        OWNER_0 = 1'b0,
        OWNER_1 = 1'b1
    } owner_t;

    owner_t           r_last;
    owner_t           w_last_nxt;
    owner_t           w_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_rd_pend;
    logic [1:0]       w_rd_pend_nxt;
    logic             w_burst_open;
    logic             w_gnt0;
    logic             w_gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last    <= OWNER_0;
            r_cnt     <= '0;
            r_rd_pend <= '0;
        end else begin
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_rd_pend_nxt;
        end
    end

    // Grants are gated by rst so the memory goes idle the instant reset asserts.
    always_comb begin
        w_burst_open = (r_cnt < MAX_CNT);
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        if (!rst) begin
            if (r_last == OWNER_0) begin
                if (req0 && (!req1 || w_burst_open)) w_gnt0 = 1'b1;
                else if (req1)                       w_gnt1 = 1'b1;
            end else begin
                if (req1 && (!req0 || w_burst_open)) w_gnt1 = 1'b1;
                else if (req0)                       w_gnt0 = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner    = w_gnt1 ? OWNER_1 : OWNER_0;
        w_last_nxt = r_last;
        w_cnt_nxt  = '0;
        if (w_gnt0 || w_gnt1) begin
            if (w_owner == r_last) begin
                w_cnt_nxt = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + 1'b1;
            end else begin
                w_last_nxt = w_owner;
                w_cnt_nxt  = CNT_W'(1);
            end
        end
        w_rd_pend_nxt = {w_gnt1 & ~rw1, w_gnt0 & ~rw0};
    end

    always_comb begin
        mem_addr  = '0;
        mem_rw    = 1'b0;
        mem_o_en  = 1'b0;
        mem_wdata = '0;
        if (w_gnt0) begin
            mem_addr  = addr0;
            mem_rw    = rw0;
            mem_o_en  = ~rw0;
            mem_wdata = wdata0;
        end else if (w_gnt1) begin
            mem_addr  = addr1;
            mem_rw    = rw1;
            mem_o_en  = ~rw1;
            mem_wdata = wdata1;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rd_pend[0];
    assign rvalid1 = r_rd_pend[1];
    assign rdata   = (|r_rd_pend) ? mem_rdata : '0;

endmodule
